// File: rtl/ud_counter_pkg.sv
// Shared constants and parameter legality checks
// for the up/down modulo-N counter.
package ud_counter_pkg;

  localparam logic UP   = 1'b1;
  localparam logic DOWN = 1'b0;

  localparam int WRAP_ON   = 1;
  localparam int WRAP_HOLD = 0;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  function automatic bit width_ok(int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

  function automatic bit modulus_ok(
    int     w,
    longint m
  );
    return (m >= 2) && (m <= (longint'(1) << w));
  endfunction

  function automatic bit wrap_ok(int wr);
    return (wr == WRAP_ON) || (wr == WRAP_HOLD);
  endfunction

endpackage

// File: rtl/ud_counter_n_if.sv
// Control/status bundle of the counter.
// CLK and RSTB stay plain ports on the module.
interface ud_counter_n_if #(
  parameter int WIDTH = 8
);

  logic             SCLRB;
  logic             LOADB;
  logic [WIDTH-1:0] A;
  logic             U_DB;
  logic             ENPB;
  logic             ENTB;
  logic [WIDTH-1:0] Q;
  logic             RCOB;
  logic             TC_EV;

  modport master (
    output SCLRB,
    output LOADB,
    output A,
    output U_DB,
    output ENPB,
    output ENTB,
    input  Q,
    input  RCOB,
    input  TC_EV
  );

  modport slave (
    input  SCLRB,
    input  LOADB,
    input  A,
    input  U_DB,
    input  ENPB,
    input  ENTB,
    output Q,
    output RCOB,
    output TC_EV
  );

endinterface

// File: rtl/ud_counter_tc.sv
// Terminal-state detect: top of range going up,
// zero going down.
module ud_counter_tc
  import ud_counter_pkg::*;
#(
  parameter int     WIDTH   = 8,
  parameter longint MODULUS = longint'(1) << WIDTH
) (
  input  logic [WIDTH-1:0] q,
  input  logic             dir,
  output logic             tc
);

  localparam logic [WIDTH-1:0] TOP =
    WIDTH'(MODULUS - 1);

  assign tc = (dir == UP) ? (q == TOP)
                          : (q == '0);

endmodule

// File: rtl/ud_counter_n.sv
// Synchronous up/down modulo-N counter with
// clear, load, P/T enables and cascade carry.
module ud_counter_n
  import ud_counter_pkg::*;
#(
  parameter int     WIDTH   = 8,
  parameter longint MODULUS = longint'(1) << WIDTH,
  parameter int     WRAP    = 1
) (
  input  logic           CLK,
  input  logic           RSTB,
  ud_counter_n_if.slave  bus
);

  if (!width_ok(WIDTH) ||
      !modulus_ok(WIDTH, MODULUS) ||
      !wrap_ok(WRAP)) begin : g_bad_param
    $error("ud_counter_n: illegal parameters");
  end

  if ($bits(bus.Q) != WIDTH) begin : g_bad_if
    $error("ud_counter_n: interface width");
  end

  localparam logic [WIDTH-1:0] TOP =
    WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_nxt;
  logic             ev;
  logic             ev_nxt;
  logic             tc;
  logic             clr;
  logic             ld;
  logic             cnt;

  ud_counter_tc #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_tc (
    .q   (q),
    .dir (bus.U_DB),
    .tc  (tc)
  );

  // Mutually exclusive by construction so the
  // decoder below can be unique.
  assign clr = ~bus.SCLRB;
  assign ld  = bus.SCLRB & ~bus.LOADB;
  assign cnt = bus.SCLRB & bus.LOADB &
               ~bus.ENPB & ~bus.ENTB;

  always_comb begin
    q_nxt  = q;
    ev_nxt = 1'b0;
    unique case (1'b1)
      clr: q_nxt = '0;
      ld: begin
        q_nxt = (bus.A > TOP) ? TOP : bus.A;
      end
      cnt: begin
        ev_nxt = tc;
        if (tc) begin
          if (WRAP == WRAP_ON) begin
            q_nxt = (bus.U_DB == UP) ? '0 : TOP;
          end
        end else if (bus.U_DB == UP) begin
          q_nxt = q + 1'b1;
        end else begin
          q_nxt = q - 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      q  <= '0;
      ev <= 1'b0;
    end else begin
      q  <= q_nxt;
      ev <= ev_nxt;
    end
  end

  assign bus.Q     = q;
  assign bus.TC_EV = ev;
  assign bus.RCOB  = ~(~bus.ENTB & tc);

endmodule

// File: doc/ud_counter_n.md
UD_COUNTER_N -- requirements
Module: ud_counter_n

Interface
REQ-001 Parameter WIDTH, default 8: counter width in bits, legal range 2..32.
REQ-002 Parameter MODULUS, default 2**WIDTH: count states 0..MODULUS-1, legal range 2..2**WIDTH.
REQ-003 Parameter WRAP, default 1: 1 = wrap at terminal count, 0 = hold (saturate) at terminal count.
REQ-004 Port CLK  input  1: single clock; all state changes on the rising edge.
REQ-005 Port RSTB  input  1: reset, asynchronous, active-low.
REQ-006 Port SCLRB  input  1: synchronous clear, active-low.
REQ-007 Port LOADB  input  1: synchronous parallel load, active-low.
REQ-008 Port A  input  WIDTH: parallel load data.
REQ-009 Port U_DB  input  1: direction; 1 = up, 0 = down.
REQ-010 Port ENPB  input  1: count enable P, active-low.
REQ-011 Port ENTB  input  1: count enable T, active-low; also gates RCOB.
REQ-012 Port Q  output  WIDTH: registered count.
REQ-013 Port RCOB  output  1: ripple carry out, active-low, combinational.
REQ-014 Port TC_EV  output  1: registered one-cycle pulse on a terminal-count step.

Function
REQ-015 Per-edge priority SHALL be: SCLRB=0 > LOADB=0 > count > hold.
REQ-016 SCLRB=0: Q <= 0 regardless of every other input.
REQ-017 LOADB=0 (SCLRB=1): Q <= A if A <= MODULUS-1, else Q <= MODULUS-1; enables and U_DB ignored.
REQ-018 Count step occurs when SCLRB=1, LOADB=1, ENPB=0 and ENTB=0; otherwise Q holds.
REQ-019 Terminal state SHALL be Q==MODULUS-1 when U_DB=1 and Q==0 when U_DB=0.
REQ-020 Up step, non-terminal: Q <= Q+1; down step, non-terminal: Q <= Q-1; arithmetic in WIDTH bits, never producing a value >= MODULUS.
REQ-021 Up step at terminal: WRAP=1 -> Q <= 0; WRAP=0 -> Q holds MODULUS-1.
REQ-022 Down step at terminal: WRAP=1 -> Q <= MODULUS-1; WRAP=0 -> Q holds 0.
REQ-023 RCOB SHALL be 0 exactly when ENTB=0 and Q is at the terminal state for the current U_DB; ENPB has no effect on RCOB.
REQ-024 RCOB SHALL follow a U_DB change combinationally within the same cycle.
REQ-025 TC_EV SHALL be 1 for exactly the cycle after an edge on which a count step (REQ-018) occurred at terminal state, in either WRAP mode; 0 otherwise.
REQ-026 A load or clear on the same edge suppresses TC_EV even if Q was terminal.
REQ-027 Cascading: RCOB of stage n tied to ENTB of stage n+1, shared ENPB/U_DB/CLK, SHALL yield a correct WIDTH*k-bit synchronous counter for MODULUS=2**WIDTH.

Reset
REQ-028 RSTB=0 SHALL asynchronously force Q=0 and TC_EV=0, independent of CLK.
REQ-029 While RSTB=0 all synchronous inputs SHALL be ignored; RCOB still evaluates combinationally from Q=0.
REQ-030 First active edge after RSTB deasserts SHALL apply REQ-015 normally; reset mid-count discards the step in progress.

Structure
REQ-031 Package ud_counter_pkg SHALL hold the direction encodings (UP=1, DOWN=0), WRAP mode constants and the WIDTH/MODULUS legality checks.
REQ-032 Terminal-state detect (Q, U_DB, MODULUS -> tc) SHALL be sub-module ud_counter_tc, shared by RCOB, next-state and TC_EV logic.
REQ-033 Illegal parameter combinations SHALL fail elaboration.

Verification (WIDTH=4, MODULUS=10, WRAP=1 unless stated)
REQ-034 RSTB pulse low mid-cycle with Q=7 -> Q=0, TC_EV=0 immediately, before next CLK edge.
REQ-035 LOADB=0, A=8, then 3 up steps -> Q=9, 0, 1; RCOB=0 only while Q=9 with ENTB=0; TC_EV=1 in cycle after 9->0.
REQ-036 Q=0, U_DB=0, one down step -> Q=9, TC_EV pulses; with WRAP=0 same stimulus -> Q stays 0, TC_EV still pulses.
REQ-037 LOADB=0, A=13 -> Q=9; SCLRB=0 and LOADB=0 same edge, A=5 -> Q=0, no TC_EV.
REQ-038 Q=9 up, ENPB=1, ENTB=0 -> Q holds, RCOB=0; ENTB=1 -> RCOB=1; toggle U_DB to 0 -> RCOB=1 same cycle.
REQ-039 Two instances WIDTH=4, MODULUS=16 cascaded, 300 up steps from 0 -> combined value 44 (300 mod 256), high stage increments only on low-stage 15->0.
